binary_counter_gray_src: RTL and testbench
==========================================

// Module: binary_counter_gray_src
// PURPOSE
//  Upstream source stage for the binary-to-Gray path: a modulo up/down binary counter
//  with synchronous load and a valid/ready output handshake.
//  It presents each count both as binary and as its registered Gray encoding (g = b ^ (b >> 1)).
//  It feeds the Gray converter and consumers that step through codes one accepted value at a time.
// PARAMETERS
//  WIDTH      4                   count width in bits (>=2)
//  MAX_COUNT  (1<<WIDTH)-1 = 15   terminal count; counts 0..MAX_COUNT, must be <= 2**WIDTH-1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      request one count step (up or down)
//  up         in   1      1 = increment, 0 = decrement; sampled with en
//  ld         in   1      request synchronous load; priority over en
//  ld_val     in   WIDTH  load value; values > MAX_COUNT are clamped to MAX_COUNT
//  out_ready  in   1      downstream accepts the presented value this cycle
//  out_valid  out  1      b/g hold a new, unaccepted value
//  b          out  WIDTH  registered binary count
//  g          out  WIDTH  registered Gray code of b, same cycle as b
//  tc         out  1      presented value was produced by a wrap
//  err        out  1      Gray adjacency error, sticky (only with GRAY_ADJ_CHECK_EN)
// BEHAVIOUR
//  Reset (async, rst_n=0): b=0, g=0, out_valid=0, tc=0, err=0, FSM=S_IDLE. Takes effect mid-operation at once.
//  Accept condition: acc = (ld | en) & (~out_valid | out_ready).
//  While stalled (out_valid=1 & out_ready=0), ld and en are ignored; b, g and tc hold.
//  Requesters keep ld/en asserted until accepted.
//  On acc (one-cycle latency; visible after the next clk edge):
//   - ld=1: b <= min(ld_val, MAX_COUNT); tc <= 0.
//   - ld=0, up=1: b <= (b==MAX_COUNT) ? 0 : b+1; tc <= (b==MAX_COUNT).
//   - ld=0, up=0: b <= (b==0) ? MAX_COUNT : b-1; tc <= (b==0).
//   - g <= next_b ^ (next_b >> 1); out_valid <= 1.
//  The adder is WIDTH bits wide; wrap is explicit at MAX_COUNT, never by overflow.
//  FSM:
//   - S_IDLE (out_valid=0): acc -> S_VALID; else stay.
//   - S_VALID (out_valid=1):
//     - out_ready=1 & acc -> S_VALID, next value presented back-to-back with no bubble.
//     - out_ready=1 & ~acc -> S_IDLE; out_valid <= 0; b, g and tc keep their last value.
//     - out_ready=0 -> stay; all outputs hold.
//  Simultaneous ld and en: the load wins and the step is dropped.
//  up is a don't-care when ld=1.
//  out_ready while out_valid=0 has no effect.
// CONFIGURATION
//  GRAY_ADJ_CHECK_EN defined:
//   - On every accepted step (not load), compare the new g with the previous g.
//   - If popcount(g_new ^ g_old) != 1, set err <= 1.
//   - err stays set until rst_n.
//   - A step that wraps with MAX_COUNT != 2**WIDTH-1 is exempt from the check.
//  GRAY_ADJ_CHECK_EN undefined: err tied to 0; no checker logic.
// TESTING
//  1 Reset, then en=1, up=1, out_ready=1 for 17 cycles -> b: 1,2,...,15,0,1 on consecutive cycles.
//    g=0001,0011,...,1000,0000. tc=1 only with b=0. out_valid stays 1.
//  2 Stall: b=5 presented, out_ready=0 for 3 cycles with en=1.
//    -> b=5, g=0111, out_valid=1 hold. out_ready=1 -> b=6 next cycle.
//  3 Load with clamp: MAX_COUNT=9, ld=1, ld_val=12, en=1 -> b=9, g=1101, tc=0.
//    Then en=1, up=1 -> b=0, tc=1.
//  4 Down wrap: b=0 presented, en=1, up=0, out_ready=1 -> b=15, g=1000, tc=1.
//  5 Async reset mid-stall: rst_n=0 between edges while out_valid=1.
//    -> b=0, g=0, out_valid=0, tc=0 immediately, without waiting for clk.
//  6 With GRAY_ADJ_CHECK_EN, MAX_COUNT=9: full up cycle -> err=0.
//    Force the internal g register to an illegal value via testbench force, then step -> err=1, held until reset.

Source files
------------

// File: rtl/binary_counter_gray_src_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : binary_counter_gray_src_if                                     |
// | Brief  : Step-request and valid/ready output bundle of the Gray source  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface binary_counter_gray_src_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             ld;
  logic [WIDTH-1:0] ld_val;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] g;
  logic             tc;
  logic             err;

  // master is the counter itself; slave is whatever drives requests and consumes values
  modport master (
    input  en, up, ld, ld_val, out_ready,
    output out_valid, b, g, tc, err
  );

  modport slave (
    output en, up, ld, ld_val, out_ready,
    input  out_valid, b, g, tc, err
  );
endinterface
`default_nettype wire

// File: rtl/binary_counter_gray_src.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : binary_counter_gray_src                                        |
// | Brief  : Modulo up/down counter with load, presenting binary + Gray     |
// |          over valid/ready. Define GRAY_ADJ_CHECK_EN for the sticky      |
// |          Gray adjacency checker on err.                                  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module binary_counter_gray_src #(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
  input  wire                        clk,
  input  wire                        rst_n,
  binary_counter_gray_src_if.master  bus
);

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MAX_COUNT);
  localparam bit               c_full = (MAX_COUNT == (1 << WIDTH) - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t           r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_g;
  logic             r_tc;

  logic             w_acc;
  logic             w_wrap;
  logic [WIDTH-1:0] w_ld_clamped;
  logic [WIDTH-1:0] w_step_b;
  logic [WIDTH-1:0] w_next_b;
  logic [WIDTH-1:0] w_next_g;

  assign w_acc = (bus.ld | bus.en) & (~r_valid | bus.out_ready);

  // Wrap is decided by explicit compare so a MAX_COUNT below 2**WIDTH-1 still wraps cleanly
  always_comb begin
    w_ld_clamped = (bus.ld_val > c_max) ? c_max : bus.ld_val;
    if (bus.up) begin
      w_wrap   = (r_b == c_max);
      w_step_b = w_wrap ? '0 : r_b + WIDTH'(1);
    end else begin
      w_wrap   = (r_b == '0);
      w_step_b = w_wrap ? c_max : r_b - WIDTH'(1);
    end
    w_next_b = bus.ld ? w_ld_clamped : w_step_b;
    w_next_g = w_next_b ^ (w_next_b >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_b     <= '0;
      r_g     <= '0;
      r_tc    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state <= S_VALID;
            r_valid <= 1'b1;
            r_b     <= w_next_b;
            r_g     <= w_next_g;
            r_tc    <= ~bus.ld & w_wrap;
          end
        end
        S_VALID: begin
          if (bus.out_ready) begin
            if (w_acc) begin
              r_b  <= w_next_b;
              r_g  <= w_next_g;
              r_tc <= ~bus.ld & w_wrap;
            end else begin
              // Drained: value fields keep their last contents, only valid drops
              r_state <= S_IDLE;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.b         = r_b;
  assign bus.g         = r_g;
  assign bus.tc        = r_tc;

`ifdef GRAY_ADJ_CHECK_EN
  logic r_err;
  logic w_adj_bad;

  // A truncated-range wrap legitimately jumps several Gray bits, so it is exempt
  assign w_adj_bad = ($countones(w_next_g ^ r_g) != 1) && !(w_wrap && !c_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_acc && !bus.ld && w_adj_bad) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_binary_counter_gray_src.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_binary_counter_gray_src                                     |
// | Brief  : Directed scoreboard bench for full-range and MAX_COUNT=9 DUTs  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_binary_counter_gray_src;

  typedef struct packed {
    logic       valid;
    logic [3:0] b;
    logic [3:0] g;
    logic       tc;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;
  int   nstep  = 0;

  exp_t       sb[$];
  logic [3:0] mb[2];
  logic       mvalid[2];
  logic       mtc[2];
  logic       merr[2];
  logic [3:0] maxc[2];

  binary_counter_gray_src_if #(.WIDTH(4)) bus0 ();
  binary_counter_gray_src_if #(.WIDTH(4)) bus1 ();

  binary_counter_gray_src #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  binary_counter_gray_src #(.WIDTH(4), .MAX_COUNT(9)) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] gray(input logic [3:0] v);
    logic [3:0] r;
    r[3] = v[3];
    for (int i = 0; i < 3; i++) r[i] = v[i] ^ v[i+1];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mb[i] = 4'd0; mvalid[i] = 1'b0; mtc[i] = 1'b0; merr[i] = 1'b0;
    end
  endtask

  task automatic idle_bus(input int s);
    if (s == 0) begin
      bus0.ld = 1'b0; bus0.en = 1'b0; bus0.up = 1'b0; bus0.ld_val = 4'd0; bus0.out_ready = 1'b0;
    end else begin
      bus1.ld = 1'b0; bus1.en = 1'b0; bus1.up = 1'b0; bus1.ld_val = 4'd0; bus1.out_ready = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus on DUT s, push the expected outcome, pop and compare after the edge
  task automatic step(input int s, input string tag, input logic l, input logic [3:0] lv,
                      input logic e, input logic u, input logic r);
    exp_t x;
    exp_t o;
    logic acc;
    idle_bus(1 - s);
    if (s == 0) begin
      bus0.ld = l; bus0.ld_val = lv; bus0.en = e; bus0.up = u; bus0.out_ready = r;
    end else begin
      bus1.ld = l; bus1.ld_val = lv; bus1.en = e; bus1.up = u; bus1.out_ready = r;
    end
    acc = (l | e) & (~mvalid[s] | r);
    if (acc) begin
      if (l) begin
        mb[s]  = (lv > maxc[s]) ? maxc[s] : lv;
        mtc[s] = 1'b0;
      end else if (u) begin
        mtc[s] = (mb[s] == maxc[s]);
        mb[s]  = mtc[s] ? 4'd0 : mb[s] + 4'd1;
      end else begin
        mtc[s] = (mb[s] == 4'd0);
        mb[s]  = mtc[s] ? maxc[s] : mb[s] - 4'd1;
      end
      mvalid[s] = 1'b1;
    end else if (mvalid[s] && r) begin
      mvalid[s] = 1'b0;
    end
    sb.push_back('{valid: mvalid[s], b: mb[s], g: gray(mb[s]), tc: mtc[s], err: merr[s]});
    @(posedge clk);
    @(negedge clk);
    nstep++;
    x = sb.pop_front();
    if (s == 0) o = '{valid: bus0.out_valid, b: bus0.b, g: bus0.g, tc: bus0.tc, err: bus0.err};
    else        o = '{valid: bus1.out_valid, b: bus1.b, g: bus1.g, tc: bus1.tc, err: bus1.err};
    chk($sformatf("%s#%0d valid", tag, nstep), 32'(o.valid), 32'(x.valid));
    chk($sformatf("%s#%0d b", tag, nstep), 32'(o.b), 32'(x.b));
    chk($sformatf("%s#%0d g", tag, nstep), 32'(o.g), 32'(x.g));
    chk($sformatf("%s#%0d tc", tag, nstep), 32'(o.tc), 32'(x.tc));
    chk($sformatf("%s#%0d err", tag, nstep), 32'(o.err), 32'(x.err));
  endtask

  initial begin
    maxc[0] = 4'd15;
    maxc[1] = 4'd9;
    model_reset();
    idle_bus(0);
    idle_bus(1);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst valid", 32'(bus0.out_valid), 32'd0);
    chk("rst b", 32'(bus0.b), 32'd0);
    chk("rst g", 32'(bus0.g), 32'd0);
    chk("rst tc", 32'(bus0.tc), 32'd0);
    chk("rst err", 32'(bus0.err), 32'd0);
    chk("rst9 valid", 32'(bus1.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full up count with wrap through 15 -> 0
    for (int i = 0; i < 17; i++) step(0, "up", 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    chk("up final b", 32'(bus0.b), 32'd1);
    chk("up final g", 32'(bus0.g), 32'b0001);

    // Stall holding 5, then resume to 6
    step(0, "ld5", 1'b1, 4'd5, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(0, "stall", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("stall b", 32'(bus0.b), 32'd5);
    chk("stall g", 32'(bus0.g), 32'b0111);
    step(0, "resume", 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    chk("resume b", 32'(bus0.b), 32'd6);

    // Drain to idle, ready while idle is harmless, load wins over step
    step(0, "drain", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    step(0, "idle", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
    step(0, "ldwin", 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);

    // Down wrap 0 -> 15
    step(0, "down", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    chk("down b", 32'(bus0.b), 32'd15);
    chk("down g", 32'(bus0.g), 32'b1000);
    chk("down tc", 32'(bus0.tc), 32'd1);
    step(0, "down2", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);

    // MAX_COUNT=9: clamped load then wrap
    step(1, "clamp", 1'b1, 4'd12, 1'b1, 1'b1, 1'b1);
    chk("clamp b", 32'(bus1.b), 32'd9);
    chk("clamp g", 32'(bus1.g), 32'b1101);
    chk("clamp tc", 32'(bus1.tc), 32'd0);
    step(1, "wrap9", 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    chk("wrap9 b", 32'(bus1.b), 32'd0);
    chk("wrap9 tc", 32'(bus1.tc), 32'd1);
    step(1, "down9", 1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    step(1, "up9", 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);

`ifdef GRAY_ADJ_CHECK_EN
    begin
      logic [3:0] fv;
      for (int i = 0; i < 10; i++) step(1, "adj", 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
      fv = ~gray(mb[1]);
      force dut9.r_g = fv;
      #1 release dut9.r_g;
      merr[1] = 1'b1;
      for (int i = 0; i < 3; i++) step(1, "adjerr", 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
    end
`endif

    // Async reset in the middle of a stall
    step(0, "ld7", 1'b1, 4'd7, 1'b0, 1'b1, 1'b1);
    step(0, "hold7", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst valid", 32'(bus0.out_valid), 32'd0);
    chk("arst b", 32'(bus0.b), 32'd0);
    chk("arst g", 32'(bus0.g), 32'd0);
    chk("arst tc", 32'(bus0.tc), 32'd0);
    chk("arst9 err", 32'(bus1.err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, "post", 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
